// File: rtl/axi4_pkg.sv
// Shared definitions for the AXI4 burst memory responder.
//   - burst and response encodings
//   - write / read FSM state types
//   - next_addr(): per-beat address update for FIXED, INCR and WRAP bursts.
//     It works on a wide address, so callers truncate the result to their own
//     width. Keeping only the low bits gives the same answer as doing the
//     arithmetic modulo the narrower width.
package axi4_pkg;

    localparam int ADDR_MAX = 32;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    function automatic logic [ADDR_MAX-1:0] next_addr(
        input logic [ADDR_MAX-1:0] addr,
        input logic [2:0]          size,
        input logic [7:0]          len,
        input logic [1:0]          burst
    );
        logic [ADDR_MAX-1:0] inc;
        logic [ADDR_MAX-1:0] bound;
        logic [ADDR_MAX-1:0] res;
        inc   = ADDR_MAX'(1) << size;
        bound = (ADDR_MAX'(len) + ADDR_MAX'(1)) * inc;
        case (burst)
            BURST_FIXED: res = addr;
            BURST_WRAP:  res = (addr & ~(bound - 1)) | ((addr + inc) & (bound - 1));
            // INCR, and the reserved encoding, which runs as INCR
            default:     res = (addr & ~(inc - 1)) + inc;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat address and burst configuration check.
//   addr/len/size/burst : current beat address and burst attributes
//   addr_next           : address of the following beat (wraps at 2^G_ADDR_WIDTH)
//   cfg_err             : illegal size, reserved burst type or illegal WRAP length
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int G_ADDR_WIDTH = 6
) (
    input  logic [G_ADDR_WIDTH-1:0] addr,
    input  logic [7:0]              len,
    input  logic [2:0]              size,
    input  logic [1:0]              burst,
    output logic [G_ADDR_WIDTH-1:0] addr_next,
    output logic                    cfg_err
);

    logic wrap_len_ok;

    always_comb begin
        addr_next   = G_ADDR_WIDTH'(next_addr(ADDR_MAX'(addr), size, len, burst));
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        cfg_err     = (size > 3'd2) || (burst == BURST_RSVD) ||
                      ((burst == BURST_WRAP) && !wrap_len_ok);
    end

endmodule

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 subordinate backed by a small register-file memory.
// The read path and the write path are independent. Each one supports
// FIXED, INCR and WRAP bursts, per-byte write strobes and SLVERR responses.
//   ACLK, ARESETn        : clock, asynchronous active-low reset
//   S_AXI_AW* / S_AXI_W* : write address and write data channels
//   S_AXI_B*             : write response channel
//   S_AXI_AR* / S_AXI_R* : read address and read data channels
//   dbg_w_state/dbg_r_state : current FSM states, for observation only
// Handshake rule for every channel: a transfer happens on a rising ACLK edge
// where VALID and READY are both high. A source holds VALID and its payload
// steady until that edge. Every READY and VALID driven here comes from a
// register.
module axi4_burst_mem_slave
    import axi4_pkg::*;
#(
    parameter int G_ADDR_WIDTH = 6,
    parameter int G_DATA_WIDTH = 32,
    parameter int G_ID_WIDTH   = 1
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [G_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                S_AXI_AWLEN,
    input  logic [2:0]                S_AXI_AWSIZE,
    input  logic [1:0]                S_AXI_AWBURST,
    input  logic [G_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [2:0]                S_AXI_AWPROT,
    input  logic                      S_AXI_AWVALID,
    output logic                      S_AXI_AWREADY,
    input  logic [G_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [G_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                      S_AXI_WLAST,
    input  logic                      S_AXI_WVALID,
    output logic                      S_AXI_WREADY,
    output logic [G_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                S_AXI_BRESP,
    output logic                      S_AXI_BVALID,
    input  logic                      S_AXI_BREADY,
    input  logic [G_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                S_AXI_ARLEN,
    input  logic [2:0]                S_AXI_ARSIZE,
    input  logic [1:0]                S_AXI_ARBURST,
    input  logic [G_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [2:0]                S_AXI_ARPROT,
    input  logic                      S_AXI_ARVALID,
    output logic                      S_AXI_ARREADY,
    output logic [G_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [G_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [1:0]                S_AXI_RRESP,
    output logic                      S_AXI_RLAST,
    output logic                      S_AXI_RVALID,
    input  logic                      S_AXI_RREADY,
    output w_state_t                  dbg_w_state,
    output r_state_t                  dbg_r_state
);

    localparam int DEPTH = 2 ** (G_ADDR_WIDTH - 2);
    localparam int NB    = G_DATA_WIDTH / 8;

    logic [G_DATA_WIDTH-1:0] mem [DEPTH];

    // PROT carries no meaning for this memory.
    logic unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // ---------------- write path ----------------
    w_state_t                w_state, w_next;
    logic [G_ADDR_WIDTH-1:0] w_addr, w_addr_nxt;
    logic [7:0]              w_len, w_cnt;
    logic [2:0]              w_size;
    logic [1:0]              w_burst;
    logic [G_ID_WIDTH-1:0]   w_id;
    logic                    w_last_err, w_cfg_err;
    logic                    aw_hs, w_hs, b_hs, w_final, w_beat_err;
    logic                    awready_d, wready_d, bvalid_d;
    logic [1:0]              bresp_d;
    logic [G_ID_WIDTH-1:0]   bid_d;

    axi4_burst_addr_gen #(.G_ADDR_WIDTH(G_ADDR_WIDTH)) u_w_gen (
        .addr(w_addr), .len(w_len), .size(w_size), .burst(w_burst),
        .addr_next(w_addr_nxt), .cfg_err(w_cfg_err)
    );

    assign aw_hs      = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs       = S_AXI_WVALID && S_AXI_WREADY;
    assign b_hs       = S_AXI_BVALID && S_AXI_BREADY;
    assign w_final    = (w_cnt == w_len);
    // The beat count alone ends the burst. WLAST is only checked against it.
    assign w_beat_err = (S_AXI_WLAST != w_final);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_final) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Output values are computed from the next state and then registered,
    // so every READY/VALID comes from a flop and resets to 0.
    always_comb begin
        awready_d = (w_next == W_IDLE);
        wready_d  = (w_next == W_DATA);
        bvalid_d  = (w_next == W_RESP);
        bresp_d   = S_AXI_BRESP;
        bid_d     = S_AXI_BID;
        if ((w_state == W_DATA) && w_hs && w_final) begin
            bid_d   = w_id;
            bresp_d = (w_cfg_err || w_last_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            S_AXI_BID     <= '0;
            w_addr        <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_size        <= '0;
            w_burst       <= '0;
            w_id          <= '0;
            w_last_err    <= 1'b0;
        end else begin
            S_AXI_AWREADY <= awready_d;
            S_AXI_WREADY  <= wready_d;
            S_AXI_BVALID  <= bvalid_d;
            S_AXI_BRESP   <= bresp_d;
            S_AXI_BID     <= bid_d;
            if (aw_hs) begin
                w_addr     <= S_AXI_AWADDR;
                w_len      <= S_AXI_AWLEN;
                w_size     <= S_AXI_AWSIZE;
                w_burst    <= S_AXI_AWBURST;
                w_id       <= S_AXI_AWID;
                w_cnt      <= '0;
                w_last_err <= 1'b0;
            end else if (w_hs) begin
                w_addr <= w_addr_nxt;
                w_cnt  <= w_cnt + 8'd1;
                if (w_beat_err) w_last_err <= 1'b1;
            end
        end
    end

    // A burst with a bad configuration still accepts its beats but does not
    // write memory. Memory is not cleared by reset.
    always_ff @(posedge ACLK) begin
        if (w_hs && !w_cfg_err) begin
            for (int i = 0; i < NB; i++) begin
                if (S_AXI_WSTRB[i])
                    mem[w_addr[G_ADDR_WIDTH-1:2]][i*8 +: 8] <= S_AXI_WDATA[i*8 +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    r_state_t                r_state, r_next;
    logic [G_ADDR_WIDTH-1:0] r_addr, r_addr_nxt, rg_addr;
    logic [7:0]              r_len, r_cnt, rg_len;
    logic [2:0]              r_size, rg_size;
    logic [1:0]              r_burst, rg_burst;
    logic                    r_cfg_err, ar_hs, r_hs, r_final;
    logic                    arready_d, rvalid_d, rlast_d;
    logic [G_DATA_WIDTH-1:0] rdata_d;
    logic [1:0]              rresp_d;
    logic [G_ID_WIDTH-1:0]   rid_d;

    // While idle, the checker looks at the AR request so the response code is
    // ready with the first beat. During a burst it steps the latched address.
    always_comb begin
        if (r_state == R_IDLE) begin
            rg_addr = S_AXI_ARADDR; rg_len = S_AXI_ARLEN;
            rg_size = S_AXI_ARSIZE; rg_burst = S_AXI_ARBURST;
        end else begin
            rg_addr = r_addr; rg_len = r_len;
            rg_size = r_size; rg_burst = r_burst;
        end
    end

    axi4_burst_addr_gen #(.G_ADDR_WIDTH(G_ADDR_WIDTH)) u_r_gen (
        .addr(rg_addr), .len(rg_len), .size(rg_size), .burst(rg_burst),
        .addr_next(r_addr_nxt), .cfg_err(r_cfg_err)
    );

    assign ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_hs    = S_AXI_RVALID && S_AXI_RREADY;
    assign r_final = (r_cnt == r_len);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        if ((r_state == R_IDLE) && ar_hs)               r_next = R_DATA;
        else if ((r_state == R_DATA) && r_hs && r_final) r_next = R_IDLE;
    end

    // RDATA is loaded on the same edge that accepts the current beat, so a
    // burst streams one beat per cycle. Memory is read before the write on
    // that edge lands, so a read of the word being written sees the old data.
    always_comb begin
        arready_d = (r_next == R_IDLE);
        rvalid_d  = (r_next == R_DATA);
        rdata_d   = S_AXI_RDATA;
        rlast_d   = S_AXI_RLAST;
        rresp_d   = S_AXI_RRESP;
        rid_d     = S_AXI_RID;
        if (ar_hs) begin
            rdata_d = mem[S_AXI_ARADDR[G_ADDR_WIDTH-1:2]];
            rid_d   = S_AXI_ARID;
            rlast_d = (S_AXI_ARLEN == 8'd0);
            rresp_d = r_cfg_err ? RESP_SLVERR : RESP_OKAY;
        end else if ((r_state == R_DATA) && r_hs) begin
            if (!r_final) begin
                rdata_d = mem[r_addr_nxt[G_ADDR_WIDTH-1:2]];
                rlast_d = ((r_cnt + 8'd1) == r_len);
            end else begin
                rlast_d = 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RLAST   <= 1'b0;
            S_AXI_RRESP   <= RESP_OKAY;
            S_AXI_RID     <= '0;
            r_addr        <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_size        <= '0;
            r_burst       <= '0;
        end else begin
            S_AXI_ARREADY <= arready_d;
            S_AXI_RVALID  <= rvalid_d;
            S_AXI_RDATA   <= rdata_d;
            S_AXI_RLAST   <= rlast_d;
            S_AXI_RRESP   <= rresp_d;
            S_AXI_RID     <= rid_d;
            if (ar_hs) begin
                r_addr  <= S_AXI_ARADDR;
                r_len   <= S_AXI_ARLEN;
                r_size  <= S_AXI_ARSIZE;
                r_burst <= S_AXI_ARBURST;
                r_cnt   <= '0;
            end else if (r_hs && !r_final) begin
                r_addr <= r_addr_nxt;
                r_cnt  <= r_cnt + 8'd1;
            end
        end
    end

    assign dbg_w_state = w_state;
    assign dbg_r_state = r_state;

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Directed bench for axi4_burst_mem_slave. Each scenario task drives a
// stimulus and checks the results against hand-computed values.
module tb_axi4_burst_mem_slave;
    import axi4_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [5:0]  S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
    logic [7:0]  S_AXI_AWLEN = '0, S_AXI_ARLEN = '0;
    logic [2:0]  S_AXI_AWSIZE = '0, S_AXI_ARSIZE = '0;
    logic [1:0]  S_AXI_AWBURST = '0, S_AXI_ARBURST = '0;
    logic        S_AXI_AWID = 1'b0, S_AXI_ARID = 1'b0;
    logic [2:0]  S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
    logic        S_AXI_AWVALID = 1'b0, S_AXI_ARVALID = 1'b0;
    logic        S_AXI_AWREADY, S_AXI_ARREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WLAST = 1'b0, S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic        S_AXI_BID;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [31:0] S_AXI_RDATA;
    logic        S_AXI_RID;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST, S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    w_state_t    dbg_w_state;
    r_state_t    dbg_r_state;

    int asserts = 0;
    int failures = 0;

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd [16];
    logic [1:0]  rr [16];
    logic        rl [16];
    logic        rid_got;

    axi4_burst_mem_slave dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN), .S_AXI_AWSIZE(S_AXI_AWSIZE),
        .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARSIZE(S_AXI_ARSIZE),
        .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RID(S_AXI_RID), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .dbg_w_state(dbg_w_state), .dbg_r_state(dbg_r_state)
    );

    // ---------------- clock ----------------
    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic send_aw(input logic [5:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bu, input logic id);
        int n = 0;
        S_AXI_AWADDR = a; S_AXI_AWLEN = len; S_AXI_AWSIZE = sz;
        S_AXI_AWBURST = bu; S_AXI_AWID = id; S_AXI_AWVALID = 1'b1;
        while (S_AXI_AWREADY !== 1'b1 && n < 20) begin @(posedge ACLK); #1; n++; end
        asserts++;
        if (n >= 20) begin failures++; $display("FAIL aw_wait: AWREADY=%b after 20 cycles, required 1", S_AXI_AWREADY); end
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [7:0] len, input int wl);
        for (int i = 0; i <= int'(len); i++) begin
            int n = 0;
            S_AXI_WDATA = wd[i]; S_AXI_WSTRB = ws[i];
            S_AXI_WLAST = (i == wl); S_AXI_WVALID = 1'b1;
            while (S_AXI_WREADY !== 1'b1 && n < 20) begin @(posedge ACLK); #1; n++; end
            asserts++;
            if (n >= 20) begin failures++; $display("FAIL w_wait: beat %0d WREADY=%b, required 1", i, S_AXI_WREADY); end
            @(posedge ACLK); #1;
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp, output logic bid);
        int n = 0;
        while (S_AXI_BVALID !== 1'b1 && n < 20) begin @(posedge ACLK); #1; n++; end
        asserts++;
        if (n >= 20) begin failures++; $display("FAIL b_wait: BVALID=%b after 20 cycles, required 1", S_AXI_BVALID); end
        resp = S_AXI_BRESP; bid = S_AXI_BID;
    endtask

    task automatic ack_b();
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [7:0] len, input logic [2:0] sz,
                            input logic [1:0] bu, input logic id, input int wl,
                            output logic [1:0] resp, output logic bid);
        send_aw(a, len, sz, bu, id);
        send_w(len, wl);
        wait_b(resp, bid);
        ack_b();
    endtask

    task automatic send_ar(input logic [5:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bu, input logic id);
        int n = 0;
        S_AXI_ARADDR = a; S_AXI_ARLEN = len; S_AXI_ARSIZE = sz;
        S_AXI_ARBURST = bu; S_AXI_ARID = id; S_AXI_ARVALID = 1'b1;
        while (S_AXI_ARREADY !== 1'b1 && n < 20) begin @(posedge ACLK); #1; n++; end
        asserts++;
        if (n >= 20) begin failures++; $display("FAIL ar_wait: ARREADY=%b after 20 cycles, required 1", S_AXI_ARREADY); end
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
    endtask

    task automatic recv_r(input logic [7:0] len);
        S_AXI_RREADY = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            int n = 0;
            while (S_AXI_RVALID !== 1'b1 && n < 20) begin @(posedge ACLK); #1; n++; end
            asserts++;
            if (n >= 20) begin failures++; $display("FAIL r_wait: beat %0d RVALID=%b, required 1", i, S_AXI_RVALID); end
            rd[i] = S_AXI_RDATA; rr[i] = S_AXI_RRESP; rl[i] = S_AXI_RLAST; rid_got = S_AXI_RID;
            @(posedge ACLK); #1;
        end
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bu, input logic id);
        send_ar(a, len, sz, bu, id);
        recv_r(len);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        ARESETn = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        asserts++;
        if ({S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: AW/AR/W-ready,BVALID,RVALID=%b, required 00000",
                     {S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID});
        end
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        asserts++;
        if (S_AXI_AWREADY !== 1'b0) begin failures++; $display("FAIL reset_release_early: AWREADY=%b, required 0", S_AXI_AWREADY); end
        @(posedge ACLK); #1;
        asserts++;
        if ({S_AXI_AWREADY, S_AXI_ARREADY} !== 2'b11) begin
            failures++; $display("FAIL reset_first_edge: AWREADY,ARREADY=%b, required 11", {S_AXI_AWREADY, S_AXI_ARREADY});
        end
        asserts++;
        if (dbg_w_state !== W_IDLE || dbg_r_state !== R_IDLE) begin
            failures++; $display("FAIL reset_state: w=%0d r=%0d, required 0 0", dbg_w_state, dbg_r_state);
        end
    endtask

    task automatic test_single();
        logic [1:0] resp; logic bid;
        wd[0] = 32'h0756_3314; ws[0] = 4'hF;
        do_write(6'h05, 8'd0, 3'd2, BURST_INCR, 1'b1, 0, resp, bid);
        asserts++;
        if (resp !== RESP_OKAY || bid !== 1'b1) begin
            failures++; $display("FAIL single_bresp: BRESP=%b BID=%b, required 00 1", resp, bid);
        end
        do_read(6'h04, 8'd0, 3'd2, BURST_INCR, 1'b1);
        asserts++;
        if (rd[0] !== 32'h0756_3314 || rl[0] !== 1'b1 || rr[0] !== RESP_OKAY || rid_got !== 1'b1) begin
            failures++; $display("FAIL single_read: RDATA=%h RLAST=%b RRESP=%b RID=%b, required 07563314 1 00 1",
                                 rd[0], rl[0], rr[0], rid_got);
        end
        asserts++;
        if ({S_AXI_RVALID, S_AXI_ARREADY} !== 2'b01) begin
            failures++; $display("FAIL single_read_end: RVALID,ARREADY=%b, required 01", {S_AXI_RVALID, S_AXI_ARREADY});
        end
    endtask

    task automatic test_incr_rollover();
        logic [1:0] resp; logic bid;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_write(6'h3C, 8'd3, 3'd2, BURST_INCR, 1'b0, 3, resp, bid);
        asserts++;
        if (resp !== RESP_OKAY) begin failures++; $display("FAIL incr_bresp: BRESP=%b, required 00", resp); end
        do_read(6'h3C, 8'd3, 3'd2, BURST_INCR, 1'b0);
        for (int i = 0; i < 4; i++) begin
            asserts++;
            if (rd[i] !== 32'(i + 1) || rl[i] !== (i == 3)) begin
                failures++; $display("FAIL incr_read beat %0d: RDATA=%h RLAST=%b, required %h %b", i, rd[i], rl[i], 32'(i + 1), (i == 3));
            end
        end
        do_read(6'h00, 8'd0, 3'd2, BURST_INCR, 1'b0);
        asserts++;
        if (rd[0] !== 32'd2) begin failures++; $display("FAIL incr_rollover_word0: RDATA=%h, required 00000002", rd[0]); end
    endtask

    task automatic test_wrap_read();
        logic [1:0] resp; logic bid;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        do_write(6'h10, 8'd3, 3'd2, BURST_INCR, 1'b0, 3, resp, bid);
        send_ar(6'h18, 8'd3, 3'd2, BURST_WRAP, 1'b1);
        S_AXI_RREADY = 1'b1;
        asserts++;
        if (S_AXI_RDATA !== 32'hA2 || S_AXI_RLAST !== 1'b0 || S_AXI_RRESP !== RESP_OKAY) begin
            failures++; $display("FAIL wrap_beat0: RDATA=%h RLAST=%b RRESP=%b, required a2 0 00", S_AXI_RDATA, S_AXI_RLAST, S_AXI_RRESP);
        end
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
        asserts++;
        if (S_AXI_RDATA !== 32'hA3 || S_AXI_RLAST !== 1'b0) begin
            failures++; $display("FAIL wrap_beat1: RDATA=%h RLAST=%b, required a3 0", S_AXI_RDATA, S_AXI_RLAST);
        end
        @(posedge ACLK); #1;
        asserts++;
        if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'hA3 || S_AXI_RLAST !== 1'b0) begin
            failures++; $display("FAIL wrap_hold: RVALID=%b RDATA=%h RLAST=%b, required 1 a3 0", S_AXI_RVALID, S_AXI_RDATA, S_AXI_RLAST);
        end
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        asserts++;
        if (S_AXI_RDATA !== 32'hA0 || S_AXI_RLAST !== 1'b0) begin
            failures++; $display("FAIL wrap_beat2: RDATA=%h RLAST=%b, required a0 0", S_AXI_RDATA, S_AXI_RLAST);
        end
        @(posedge ACLK); #1;
        asserts++;
        if (S_AXI_RDATA !== 32'hA1 || S_AXI_RLAST !== 1'b1) begin
            failures++; $display("FAIL wrap_beat3: RDATA=%h RLAST=%b, required a1 1", S_AXI_RDATA, S_AXI_RLAST);
        end
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
        asserts++;
        if ({S_AXI_RVALID, S_AXI_ARREADY} !== 2'b01) begin
            failures++; $display("FAIL wrap_end: RVALID,ARREADY=%b, required 01", {S_AXI_RVALID, S_AXI_ARREADY});
        end
    endtask

    task automatic test_strobe_read_first();
        logic [1:0] resp; logic bid;
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        do_write(6'h20, 8'd0, 3'd2, BURST_INCR, 1'b0, 0, resp, bid);
        send_aw(6'h20, 8'd0, 3'd2, BURST_INCR, 1'b0);
        // The write beat and the read address handshake share one edge.
        S_AXI_WDATA = 32'h1122_3344; S_AXI_WSTRB = 4'h5; S_AXI_WLAST = 1'b1; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 6'h20; S_AXI_ARLEN = 8'd0; S_AXI_ARSIZE = 3'd2;
        S_AXI_ARBURST = BURST_INCR; S_AXI_ARID = 1'b0; S_AXI_ARVALID = 1'b1;
        asserts++;
        if ({S_AXI_WREADY, S_AXI_ARREADY} !== 2'b11) begin
            failures++; $display("FAIL same_cycle_ready: WREADY,ARREADY=%b, required 11", {S_AXI_WREADY, S_AXI_ARREADY});
        end
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0; S_AXI_ARVALID = 1'b0;
        asserts++;
        if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL read_first: RVALID=%b RDATA=%h, required 1 ffffffff", S_AXI_RVALID, S_AXI_RDATA);
        end
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
        wait_b(resp, bid);
        ack_b();
        asserts++;
        if (resp !== RESP_OKAY) begin failures++; $display("FAIL strobe_bresp: BRESP=%b, required 00", resp); end
        do_read(6'h20, 8'd0, 3'd2, BURST_INCR, 1'b0);
        asserts++;
        if (rd[0] !== 32'hFF22_FF44) begin failures++; $display("FAIL strobe_merge: RDATA=%h, required ff22ff44", rd[0]); end
    endtask

    task automatic test_errors();
        logic [1:0] resp; logic bid;
        // SIZE 3: SLVERR and memory left alone
        wd[0] = 32'h5A5A_5A5A; ws[0] = 4'hF;
        do_write(6'h24, 8'd0, 3'd2, BURST_INCR, 1'b0, 0, resp, bid);
        wd[0] = 32'h0000_0000;
        do_write(6'h24, 8'd0, 3'd3, BURST_INCR, 1'b1, 0, resp, bid);
        asserts++;
        if (resp !== RESP_SLVERR) begin failures++; $display("FAIL size3_bresp: BRESP=%b, required 10", resp); end
        do_read(6'h24, 8'd0, 3'd2, BURST_INCR, 1'b0);
        asserts++;
        if (rd[0] !== 32'h5A5A_5A5A) begin failures++; $display("FAIL size3_mem: RDATA=%h, required 5a5a5a5a", rd[0]); end
        // reserved burst type: SLVERR and no memory update
        wd[0] = 32'h1234_5678;
        do_write(6'h28, 8'd0, 3'd2, BURST_INCR, 1'b0, 0, resp, bid);
        wd[0] = 32'h0;
        do_write(6'h28, 8'd0, 3'd2, BURST_RSVD, 1'b0, 0, resp, bid);
        asserts++;
        if (resp !== RESP_SLVERR) begin failures++; $display("FAIL rsvd_bresp: BRESP=%b, required 10", resp); end
        do_read(6'h28, 8'd0, 3'd2, BURST_INCR, 1'b0);
        asserts++;
        if (rd[0] !== 32'h1234_5678) begin failures++; $display("FAIL rsvd_mem: RDATA=%h, required 12345678", rd[0]); end
        // WRAP with LEN 2: every beat SLVERR, three beats returned
        do_read(6'h10, 8'd2, 3'd2, BURST_WRAP, 1'b0);
        for (int i = 0; i < 3; i++) begin
            asserts++;
            if (rr[i] !== RESP_SLVERR || rl[i] !== (i == 2)) begin
                failures++; $display("FAIL wrap_len2 beat %0d: RRESP=%b RLAST=%b, required 10 %b", i, rr[i], rl[i], (i == 2));
            end
        end
        // WLAST on the first of three beats: all beats taken, SLVERR, data written
        for (int i = 0; i < 3; i++) begin wd[i] = 32'hC0 + 32'(i); ws[i] = 4'hF; end
        do_write(6'h30, 8'd2, 3'd2, BURST_INCR, 1'b1, 0, resp, bid);
        asserts++;
        if (resp !== RESP_SLVERR || bid !== 1'b1) begin
            failures++; $display("FAIL wlast_early_bresp: BRESP=%b BID=%b, required 10 1", resp, bid);
        end
        do_read(6'h30, 8'd2, 3'd2, BURST_INCR, 1'b0);
        for (int i = 0; i < 3; i++) begin
            asserts++;
            if (rd[i] !== 32'hC0 + 32'(i)) begin
                failures++; $display("FAIL wlast_early_data beat %0d: RDATA=%h, required %h", i, rd[i], 32'hC0 + 32'(i));
            end
        end
    endtask

    task automatic test_bready_hold();
        logic [1:0] resp; logic bid;
        wd[0] = 32'hBEEF_0001; ws[0] = 4'hF;
        send_aw(6'h2C, 8'd0, 3'd2, BURST_INCR, 1'b0);
        send_w(8'd0, 0);
        wait_b(resp, bid);
        for (int k = 0; k < 5; k++) begin
            @(posedge ACLK); #1;
            asserts++;
            if ({S_AXI_BVALID, S_AXI_AWREADY} !== 2'b10 || S_AXI_BRESP !== RESP_OKAY) begin
                failures++; $display("FAIL bready_hold cycle %0d: BVALID,AWREADY=%b BRESP=%b, required 10 00",
                                     k, {S_AXI_BVALID, S_AXI_AWREADY}, S_AXI_BRESP);
            end
        end
        ack_b();
        asserts++;
        if ({S_AXI_BVALID, S_AXI_AWREADY} !== 2'b01) begin
            failures++; $display("FAIL bready_release: BVALID,AWREADY=%b, required 01", {S_AXI_BVALID, S_AXI_AWREADY});
        end
    endtask

    task automatic test_reset_mid_read();
        send_ar(6'h00, 8'd7, 3'd2, BURST_INCR, 1'b1);
        S_AXI_RREADY = 1'b1;
        repeat (2) begin @(posedge ACLK); #1; end
        #2;
        ARESETn = 1'b0;
        #1;
        asserts++;
        if ({S_AXI_RVALID, S_AXI_ARREADY} !== 2'b00) begin
            failures++; $display("FAIL async_reset: RVALID,ARREADY=%b, required 00", {S_AXI_RVALID, S_AXI_ARREADY});
        end
        S_AXI_RREADY = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        asserts++;
        if (S_AXI_ARREADY !== 1'b0) begin failures++; $display("FAIL reset_release_ar: ARREADY=%b, required 0", S_AXI_ARREADY); end
        @(posedge ACLK); #1;
        asserts++;
        if (S_AXI_ARREADY !== 1'b1) begin failures++; $display("FAIL reset_ar_after: ARREADY=%b, required 1", S_AXI_ARREADY); end
        do_read(6'h04, 8'd0, 3'd2, BURST_INCR, 1'b0);
        asserts++;
        if (rd[0] !== 32'd3) begin failures++; $display("FAIL mem_kept: RDATA=%h, required 00000003", rd[0]); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 4'hF; rd[i] = '0; rr[i] = '0; rl[i] = 1'b0; end
        rid_got = 1'b0;
        test_reset();
        test_single();
        test_incr_rollover();
        test_wrap_read();
        test_strobe_read_first();
        test_errors();
        test_bready_hold();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
